// File: rtl/rf_scan_pkg.sv
// rf_scan_pkg: shared widths and FSM state encoding for the register-file
// scan reader, also used by the register file and the debug unit.
package rf_scan_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/rf_scan_reader_if.sv
// rf_scan_reader_if: register-file read port plus the (index, value) stream.
// master = scan reader side, slave = register file / debug unit side.
interface rf_scan_reader_if
    import rf_scan_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output ra, out_valid, out_addr, out_data,
        input  rd, out_ready
    );

    modport slave (
        input  ra, out_valid, out_addr, out_data,
        output rd, out_ready
    );

endinterface

// File: rtl/rf_scan_reader.sv
// rf_scan_reader: sweeps the register file through its spare asynchronous
// read port and streams each (index, value) pair over valid/ready.
// Optional feature macro: RF_SCAN_CHECKSUM_EN adds a rotate/XOR checksum
// output chk over every accepted value of the scan.
module rf_scan_reader
    import rf_scan_pkg::*;
#(
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    rf_scan_reader_if.master bus,
    output logic             busy,
    output logic             done
`ifdef RF_SCAN_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk
`endif
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    // next index of the sweep; only used while idx_q < LAST_A, so no wrap
    assign idx_d = idx_q + ADDR_W'(1);

`ifdef RF_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q;
    logic [DATA_W-1:0] chk_d;

    // fold of the pair being accepted: rotate left by one, then XOR
    assign chk_d = {chk_q[DATA_W-2:0], chk_q[DATA_W-1]} ^ data_q;
    assign chk   = chk_q;
`endif

    // scan FSM, index counter and capture registers; all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= FIRST_A;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RF_SCAN_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q   <= FIRST_A;
                        busy_q  <= 1'b1;
                        state_q <= ST_READ;
`ifdef RF_SCAN_CHECKSUM_EN
                        chk_q   <= '0;
`endif
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        idx_q   <= FIRST_A;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        // ra is idx_q, so rd is this register's value now
                        addr_q  <= idx_q;
                        data_q  <= bus.rd;
                        valid_q <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        // abort beats a same-cycle handshake; the pair is dropped
                        valid_q <= 1'b0;
                        idx_q   <= FIRST_A;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (bus.out_ready) begin
                        valid_q <= 1'b0;
`ifdef RF_SCAN_CHECKSUM_EN
                        chk_q   <= chk_d;
`endif
                        if (idx_q < LAST_A) begin
                            idx_q   <= idx_d;
                            state_q <= ST_READ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    idx_q   <= FIRST_A;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    idx_q   <= FIRST_A;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ra       = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.out_addr = addr_q;
    assign bus.out_data = data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_rf_scan_reader.sv
// tb_rf_scan_reader: directed + randomized scans of a modelled register file,
// checked against a pair-sequence model of the sweep.
module tb_rf_scan_reader;
    import rf_scan_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int FIRST = 0;
    localparam int LAST  = 31;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic done;
`ifdef RF_SCAN_CHECKSUM_EN
    logic [DW-1:0] chk;
`endif

    logic [DW-1:0] rf   [32];
    logic [DW-1:0] expv [32];
    int total = 0;
    int bad   = 0;

    rf_scan_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    assign bus.rd = rf[bus.ra];

    rf_scan_reader #(
        .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(FIRST), .LAST_REG(LAST)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
`ifdef RF_SCAN_CHECKSUM_EN
        ,
        .chk   (chk)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
    endtask

    task automatic preload_rand();
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    endtask

    // One scan. The model expects pair k = (k, value of x_k at the time it is
    // read). Writes are only issued while a pair is on offer at index a; a
    // register j > a has not been read yet, so the write becomes its expected
    // value, while j <= a must not disturb what was already captured.
    task automatic scan(input int rdy_pct, input int wr_pct, input int stall_idx,
                        input int dead_idx, input int abort_idx, input bit abort_with_start);
        int  nxt;
        int  ready_edge;
        int  stall;
        int  j;
        bit  fresh;
        bit  rdy;
        bit  ab;
        logic [31:0] chk_m;
        for (int i = 0; i < 32; i++) expv[i] = rf[i];
        nxt = FIRST; ready_edge = 0; stall = 0; fresh = 1'b1; chk_m = '0;
        @(negedge clk);
        start = 1'b1; abort = abort_with_start; bus.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done) begin
                check("done_timing", 32'(cyc), 32'(ready_edge));
                check("done_pairs", 32'(nxt), 32'(LAST + 1));
`ifdef RF_SCAN_CHECKSUM_EN
                check("chk_at_done", chk, chk_m);
`endif
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
                start = 1'b0;
                check("busy_after_done", 32'(busy), 32'd0);
                check("valid_after_done", 32'(bus.out_valid), 32'd0);
                check("done_one_cycle", 32'(done), 32'd0);
                return;
            end
            if (bus.out_valid) begin
                if (fresh) begin
                    check("valid_timing", 32'(cyc), 32'(ready_edge + 1));
                    fresh = 1'b0;
                    if (nxt == dead_idx) rf[nxt] = 32'hDEAD;
                end
                check("out_addr", 32'(bus.out_addr), 32'(nxt));
                check("out_data", bus.out_data, expv[nxt]);
                if (nxt == stall_idx && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = ($urandom_range(0, 99) < rdy_pct);
                end
                ab = (nxt == abort_idx);
                bus.out_ready = rdy;
                abort = ab;
                if ($urandom_range(0, 99) < wr_pct) begin
                    j = $urandom_range(1, 31);
                    rf[j] = $urandom;
                    if (j > nxt) expv[j] = rf[j];
                end
                if (ab) begin
                    @(negedge clk);
                    abort = 1'b0; start = 1'b0;
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_valid", 32'(bus.out_valid), 32'd0);
                    check("abort_no_done", 32'(done), 32'd0);
                    repeat (3) begin
                        @(negedge clk);
                        check("abort_idle_no_done", 32'(done), 32'd0);
                    end
                    return;
                end
                if (rdy) begin
                    chk_m = {chk_m[30:0], chk_m[31]} ^ expv[nxt];
                    nxt++;
                    ready_edge = cyc + 1;
                    fresh = 1'b1;
                end
            end else begin
                bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
                abort = 1'b0;
            end
            // start while busy must be ignored
            start = ($urandom_range(0, 3) == 0);
        end
        check("scan_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; bus.out_ready = 1'b0;
        preload();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_addr", 32'(bus.out_addr), 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_ra", 32'(bus.ra), 32'(FIRST));
        rst = 1'b0;

        // full dump, ready always high, no writes
        preload();
        scan(100, 0, -1, -1, -1, 1'b0);
        // back-pressure at index 4, overwrite x5 after it is captured
        preload();
        scan(100, 0, 4, 5, -1, 1'b0);
        // abort while offering index 10, then a fresh scan from index 0
        preload();
        scan(100, 0, -1, -1, 10, 1'b0);
        preload_rand();
        scan(70, 30, -1, -1, -1, 1'b1);
        // abort at the last register, possibly together with out_ready
        preload_rand();
        scan(50, 30, -1, -1, LAST, 1'b0);
        preload_rand();
        scan(60, 40, -1, -1, $urandom_range(0, LAST), 1'b0);

        // asynchronous reset while index 20 is on offer
        preload();
        @(negedge clk);
        start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_addr == 5'd20) seen = 1'b1;
        end
        check("reach_idx20", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_addr", 32'(bus.out_addr), 32'd0);
        check("arst_data", bus.out_data, 32'd0);
        check("arst_ra", 32'(bus.ra), 32'(FIRST));
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done), 32'd0);
        end
        preload_rand();
        scan(80, 20, -1, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_scan_reader.md
Name: rf_scan_reader

Overview:
- Sequential reader that sweeps the CPU register file through its spare asynchronous read port (address out, data in the same cycle).
- Streams each (index, value) pair out over a valid/ready handshake.
- Sits between the register file's third read port and the debug unit, for register dumps on single-step or halt.
- Reads only; never drives the register-file write port.

Parameters:
- ADDR_W, 5: register index width.
- DATA_W, 32: register data width.
- FIRST_REG, 0: first index scanned.
- LAST_REG, 31: last index scanned. Constraint: FIRST_REG <= LAST_REG <= 2**ADDR_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- abort  input  1  cancel the scan in progress.
- ra  output  ADDR_W  read address to the register-file read port.
- rd  input  DATA_W  combinational read data returned for ra.
- out_valid  output  1  out_addr/out_data hold a captured register.
- out_ready  input  1  consumer accepts the current pair.
- out_addr  output  ADDR_W  index of the captured register.
- out_data  output  DATA_W  captured register value.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the LAST_REG pair is accepted.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, idx=FIRST_REG, ra=FIRST_REG.
  - out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
  - Reset mid-scan discards the scan; no done is produced.
- ra is driven from the idx register only, so it is glitch-free and stable for a whole cycle.
- FSM states: IDLE, READ, SEND, FIN.
- IDLE:
  - start=1 loads idx=FIRST_REG and moves to READ.
  - All other inputs are ignored.
- READ (ra=idx):
  - At the clock edge, capture out_data<=rd and out_addr<=idx, then move to SEND.
- SEND:
  - out_valid=1; out_addr/out_data held stable until the handshake.
  - On out_valid && out_ready: if idx==LAST_REG go to FIN, else idx<=idx+1 and go to READ.
  - out_valid drops in the cycle after acceptance.
- FIN:
  - done=1 for exactly this cycle, then IDLE with idx reset to FIRST_REG.
- Latency:
  - start sampled at edge N; READ in cycle N+1; out_valid first high in cycle N+2.
  - With out_ready held at 1: 2 cycles per register. Default full dump is 64 cycles plus 1 cycle of FIN.
- Back-pressure: SEND holds indefinitely while out_ready=0; the captured value does not change.
- Data coherence: each value is the register-file content during its READ cycle. Later writes to the same index do not alter data already captured.
- abort:
  - In READ or SEND, return to IDLE at the next edge.
  - out_valid=0, no done pulse; a pair not yet accepted is dropped.
  - abort in IDLE or FIN has no effect.
- start while busy is ignored; start asserted in FIN is not registered.
- abort and out_ready accepted in the same SEND cycle: abort wins and there is no done, even at LAST_REG.
- idx never wraps past LAST_REG; the increment happens only when idx < LAST_REG.
- Index 0 is read like any other register (returns 0).

Optional Feature:
- Macro: RF_SCAN_CHECKSUM_EN.
- Defined:
  - Extra output port chk (output, DATA_W).
  - Accumulator cleared to 0 on start and on reset.
  - Each accepted out_data is folded in as chk <= (chk rotated left by 1) XOR out_data.
  - chk is valid and stable from the done cycle until the next start; abort leaves a partial value.
- Not defined: no chk port and no accumulator logic.

Decomposition:
- Shared package rf_scan_pkg:
  - State encoding constants (IDLE=2'd0, READ=2'd1, SEND=2'd2, FIN=2'd3).
  - Default ADDR_W/DATA_W, shared with the register file and debug unit.
- No sub-module: the FSM, index counter and capture registers form a single block. The checksum stays inline under the macro.

Test Plan:
- Register file preloaded with x_i = 0x100+i (x0 = 0), out_ready tied 1, pulse start -> 32 pairs (0,0x0), (1,0x101) … (31,0x11F) in order, one every 2 cycles; done exactly 1 cycle after the last acceptance; busy low the cycle after done.
- out_ready=0 for 5 cycles while SEND holds index 4 -> out_valid stays 1, out_addr=4, out_data=0x104 stable throughout; accepted on the first ready cycle.
- Write x5=0xDEAD in the cycle after index 5 was captured -> streamed value for index 5 remains 0x105.
- abort during SEND at index 10 -> IDLE next cycle, out_valid=0, no done; a new start restarts at index 0.
- rst asserted asynchronously mid-scan (index 20) -> all outputs reach reset values immediately; ra=0.
- RF_SCAN_CHECKSUM_EN defined, FIRST_REG=LAST_REG=1, x1=0x80000001 -> single pair; chk=0x80000001 at done.
